fetch_queue: RTL and testbench

Front-end prefetch unit that drives the program counter into the instruction memory and buffers the returned bytes. The instruction memory returns a 5-byte little-endian window combinationally. This block pushes each window into a circular byte queue and presents the oldest bytes to the decoder through a variable-length consume interface. It also handles pipeline redirects (branch/flush) and sits between `instr_mem` and the decode stage.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/byte_ring.sv | 37 +++
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths and constants for the fetch front end.
package fetch_pkg;
    localparam int PC_W        = 32;
    localparam int WIN_W       = 40;
    localparam int INSTR_BYTES = 5;
    localparam logic [7:0] NOP_BYTE = 8'h90;
endpackage

// File: rtl/byte_ring.sv
// Byte ring with one 5-byte write window at tail and a 5-byte combinational read window at head.
// Write lands at the clock edge; bytes beyond rd_count_i read back as NOP so stale storage never leaks out.
module byte_ring
    import fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 16
) (
    input  logic                      clk,
    input  logic                      wr_en_i,
    input  logic [$clog2(QDEPTH)-1:0] wr_ptr_i,
    input  logic [WIN_W-1:0]          wr_data_i,
    input  logic [$clog2(QDEPTH)-1:0] rd_ptr_i,
    input  logic [2:0]                rd_count_i,
    output logic [WIN_W-1:0]          rd_data_o
);
    localparam int unsigned AW = $clog2(QDEPTH);

    logic [7:0] mem_q [QDEPTH];

    // Pointer arithmetic is AW bits wide, so a window straddling the ring end wraps for free.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < INSTR_BYTES; i++) begin
                mem_q[wr_ptr_i + AW'(i)] <= wr_data_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_data_o = {INSTR_BYTES{NOP_BYTE}};
        for (int i = 0; i < INSTR_BYTES; i++) begin
            if (3'(i) < rd_count_i) begin
                rd_data_o[8*i +: 8] = mem_q[rd_ptr_i + AW'(i)];
            end
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue: pushes 5-byte imem windows into a byte ring, decoder consumes 0..5 bytes per cycle.
// Pushed bytes visible one cycle later; fetch stalls while fewer than 5 free slots remain; redirect flushes.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_pc,
    input  logic [WIN_W-1:0]  imem_instr,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [WIN_W-1:0]  dec_bytes,
    output logic [2:0]        dec_count,
    output logic [PC_W-1:0]   dec_pc,
    input  logic [2:0]        dec_take
);
    localparam int unsigned AW = $clog2(QDEPTH);

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] head_pc_q, head_pc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [AW:0]     occ_q, occ_d;
    logic            push;
    logic [2:0]      count;
    logic [2:0]      take_eff;

    assign count    = (occ_q >= (AW+1)'(INSTR_BYTES)) ? 3'(INSTR_BYTES) : occ_q[2:0];
    // Free-space test ignores this cycle's take, trading a little throughput for a short path.
    assign push     = !redirect_valid && (occ_q <= (AW+1)'(QDEPTH - INSTR_BYTES));
    assign take_eff = (dec_take < count) ? dec_take : count;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            head_pc_d  = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            occ_d      = '0;
        end else begin
            head_d    = head_q + AW'(take_eff);
            head_pc_d = head_pc_q + PC_W'(take_eff);
            occ_d     = occ_q - (AW+1)'(take_eff);
            if (push) begin
                tail_d     = tail_q + AW'(INSTR_BYTES);
                fetch_pc_d = fetch_pc_q + PC_W'(INSTR_BYTES);
                occ_d      = occ_d + (AW+1)'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
        end
    end

    byte_ring #(.QDEPTH(QDEPTH)) u_ring (
        .clk        (clk),
        .wr_en_i    (push),
        .wr_ptr_i   (tail_q),
        .wr_data_i  (imem_instr),
        .rd_ptr_i   (head_q),
        .rd_count_i (count),
        .rd_data_o  (dec_bytes)
    );

    assign imem_pc   = fetch_pc_q;
    assign dec_pc    = head_pc_q;
    assign dec_count = count;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    localparam int          QD  = 16;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [39:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [39:0] dec_bytes;
    logic [2:0]  dec_count;
    logic [31:0] dec_pc;
    logic [2:0]  dec_take;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain byte queue plus the two program counters.
    logic [7:0]  mq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_head;

    always #5 clk = ~clk;

    // Memory model: byte at address a is a[7:0].
    assign imem_instr = {imem_pc[7:0] + 8'd4, imem_pc[7:0] + 8'd3, imem_pc[7:0] + 8'd2,
                         imem_pc[7:0] + 8'd1, imem_pc[7:0]};

    fetch_queue #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_bytes      (dec_bytes),
        .dec_count      (dec_count),
        .dec_pc         (dec_pc),
        .dec_take       (dec_take)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic [2:0] tk);
        int sz;
        int avail;
        int t;
        if (r) begin
            mq.delete();
            m_fetch = RPC;
            m_head  = RPC;
        end else if (rv) begin
            mq.delete();
            m_fetch = rpc;
            m_head  = rpc;
        end else begin
            sz    = mq.size();
            avail = (sz < 5) ? sz : 5;
            t     = (int'(tk) < avail) ? int'(tk) : avail;
            for (int i = 0; i < t; i++) void'(mq.pop_front());
            m_head = m_head + 32'(t);
            if (sz <= QD - 5) begin
                for (int i = 0; i < 5; i++) mq.push_back(8'(m_fetch + 32'(i)));
                m_fetch = m_fetch + 32'd5;
            end
        end
    endtask

    task automatic check_model();
        logic [39:0] eb;
        int          sz;
        sz = mq.size();
        eb = {5{8'h90}};
        for (int i = 0; i < 5; i++) if (i < sz) eb[8*i +: 8] = mq[i];
        chk("imem_pc", 64'(imem_pc), 64'(m_fetch));
        chk("dec_pc", 64'(dec_pc), 64'(m_head));
        chk("dec_count", 64'(dec_count), 64'((sz < 5) ? sz : 5));
        chk("dec_bytes", 64'(dec_bytes), 64'(eb));
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic [2:0] tk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_take       = tk;
        @(posedge clk);
        model_update(r, rv, rpc, tk);
        #1;
        check_model();
    endtask

    initial begin
        logic [31:0] exp_pc [4];
        logic [31:0] base;
        exp_pc = '{32'd5, 32'd10, 32'd15, 32'd15};
        mq.delete();
        m_fetch = RPC;
        m_head  = RPC;

        // Reset state
        step(1'b1, 1'b0, 32'h0, 3'd0);
        chk("rst_imem_pc", 64'(imem_pc), 64'h0);
        chk("rst_dec_count", 64'(dec_count), 64'h0);
        chk("rst_dec_bytes", 64'(dec_bytes), 64'h90_9090_9090);

        // Fill with no consumption: fetch stalls once 15 bytes are queued
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h0, 3'd0);
            chk("fill_imem_pc", 64'(imem_pc), 64'(exp_pc[k]));
        end
        chk("fill_bytes", 64'(dec_bytes), 64'h04_0302_0100);
        chk("fill_count", 64'(dec_count), 64'd5);
        chk("fill_dec_pc", 64'(dec_pc), 64'h0);

        step(1'b0, 1'b0, 32'h0, 3'd1);
        chk("take1_pc", 64'(dec_pc), 64'd1);
        chk("take1_bytes", 64'(dec_bytes), 64'h05_0403_0201);
        step(1'b0, 1'b0, 32'h0, 3'd3);
        chk("take3_pc", 64'(dec_pc), 64'd4);
        chk("take3_bytes", 64'(dec_bytes), 64'h08_0706_0504);

        // Redirect beats a simultaneous take of 5
        step(1'b0, 1'b1, 32'h20, 3'd5);
        chk("redir_count", 64'(dec_count), 64'd0);
        chk("redir_imem_pc", 64'(imem_pc), 64'h20);
        chk("redir_dec_pc", 64'(dec_pc), 64'h20);
        // Over-request against an empty head is clamped to nothing
        step(1'b0, 1'b0, 32'h0, 3'd5);
        chk("redir_bytes", 64'(dec_bytes), 64'h24_2322_2120);
        chk("clamp_dec_pc", 64'(dec_pc), 64'h20);
        chk("redir_count5", 64'(dec_count), 64'd5);

        base = dec_pc;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, 32'h0, 3'd3);
            chk("take3_run_pc", 64'(dec_pc), 64'(base + 32'(3 * k)));
        end

        // Build occupancy 10, then reset mid-operation
        step(1'b0, 1'b1, 32'h0, 3'd0);
        step(1'b0, 1'b0, 32'h0, 3'd0);
        step(1'b0, 1'b0, 32'h0, 3'd0);
        chk("pre_rst_pc", 64'(imem_pc), 64'd10);
        step(1'b1, 1'b0, 32'h0, 3'd0);
        chk("midrst_count", 64'(dec_count), 64'd0);
        chk("midrst_bytes", 64'(dec_bytes), 64'h90_9090_9090);
        chk("midrst_imem_pc", 64'(imem_pc), 64'h0);
        step(1'b0, 1'b0, 32'h0, 3'd0);
        chk("refill_bytes", 64'(dec_bytes), 64'h04_0302_0100);

        // Randomized traffic against the reference model
        for (int k = 0; k < 600; k++) begin
            logic       r;
            logic       rv;
            logic [2:0] tk;
            r  = ($urandom_range(0, 79) == 0);
            rv = ($urandom_range(0, 15) == 0);
            tk = 3'($urandom_range(0, 5));
            step(r, rv, $urandom(), tk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
